// File: rtl/fx_div_seq.sv
// rtl/fx_div_seq.sv - sequential signed scaled-word divider, one non-restoring quotient bit per cycle
module fx_div_seq #(
    parameter int N         = 20,
    parameter int S         = 3,
    parameter int OUT_SCALE = 3,
    parameter int ROUND     = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic         div_zero
);

    localparam int M    = N - S;
    localparam int SMAX = (1 << S) - 1;
    localparam int WD   = M + OUT_SCALE + SMAX;
    localparam int WR   = WD + 2;
    localparam int CW   = ($clog2(WD + 1) > 5) ? $clog2(WD + 1) : 5;

    localparam logic [WD:0]   L_POS = (WD + 1)'((1 << (M - 1)) - 1);
    localparam logic [WD:0]   L_NEG = (WD + 1)'(1 << (M - 1));
    localparam logic [M-1:0]  Q_MAX = {1'b0, {(M - 1){1'b1}}};
    localparam logic [M-1:0]  Q_MIN = {1'b1, {(M - 1){1'b0}}};
    localparam logic [CW-1:0] LAST  = CW'(WD - 1);

    // Operand alignment happens on the accept edge, so there is no separate load state.
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t r_state, w_state_nx;

    logic [WR-1:0] r_rem;
    logic [WD-1:0] r_quo;
    logic [WD-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic          r_neg;
    logic          r_a_neg;
    logic          r_b_zero;

    logic [M-1:0]  w_a_m, w_b_m, w_a_mag, w_b_mag;
    logic [S-1:0]  w_a_s, w_b_s;
    logic [S:0]    w_d_sh;
    logic [WD-1:0] w_d_load, w_v_load;
    logic [WR-1:0] w_div_x, w_rem_sh, w_rem_step, w_rem_fix;
    logic          w_round_up;
    logic [WD:0]   w_mag;
    logic [M-1:0]  w_q_m;
    logic          w_ovf;

    assign w_a_m   = dividend[N-1:S];
    assign w_a_s   = dividend[S-1:0];
    assign w_b_m   = divisor[N-1:S];
    assign w_b_s   = divisor[S-1:0];
    // Unsigned M-bit magnitude keeps 2^(M-1) exact for the most negative mantissa.
    assign w_a_mag = w_a_m[M-1] ? (-w_a_m) : w_a_m;
    assign w_b_mag = w_b_m[M-1] ? (-w_b_m) : w_b_m;
    assign w_d_sh  = {1'b0, w_b_s} + (S + 1)'(OUT_SCALE);
    assign w_d_load = {{(WD - M){1'b0}}, w_a_mag} << w_d_sh;
    assign w_v_load = {{(WD - M){1'b0}}, w_b_mag} << w_a_s;

    assign w_div_x    = {2'b00, r_div};
    assign w_rem_sh   = {r_rem[WR-2:0], r_quo[WD-1]};
    assign w_rem_step = r_rem[WR-1] ? (w_rem_sh + w_div_x) : (w_rem_sh - w_div_x);
    assign w_rem_fix  = r_rem[WR-1] ? (r_rem + w_div_x) : r_rem;
    assign w_round_up = (ROUND != 0) && ({w_rem_fix, 1'b0} >= {3'b000, r_div});
    assign w_mag      = {1'b0, r_quo} + {{WD{1'b0}}, w_round_up};

    always_comb begin
        w_q_m = w_mag[M-1:0];
        w_ovf = 1'b0;
        if (r_b_zero) begin
            w_q_m = r_a_neg ? Q_MIN : Q_MAX;
        end else if (!r_neg) begin
            if (w_mag > L_POS) begin
                w_q_m = Q_MAX;
                w_ovf = 1'b1;
            end
        end else if (w_mag > L_NEG) begin
            w_q_m = Q_MIN;
            w_ovf = 1'b1;
        end else begin
            w_q_m = -w_mag[M-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_ITER;
            S_ITER:  if (r_cnt == LAST) w_state_nx = S_FIN;
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                        r_rem    <= '0;
                        r_quo    <= w_d_load;
                        r_div    <= w_v_load;
                        r_cnt    <= '0;
                        r_neg    <= w_a_m[M-1] ^ w_b_m[M-1];
                        r_a_neg  <= w_a_m[M-1];
                        r_b_zero <= (w_b_m == '0);
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_step;
                    r_quo <= {r_quo[WD-2:0], ~w_rem_step[WR-1]};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    q        <= {w_q_m, S'(OUT_SCALE)};
                    overflow <= w_ovf;
                    div_zero <= r_b_zero;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
